// File: rtl/reg_file_gen_pkg.sv
// Shared types and default sizing for the parametrised register file.
// Provides the sweep FSM state enum and the default geometry constants.
package reg_file_gen_pkg;

  typedef enum logic {
    CLEAR = 1'b0,
    RUN   = 1'b1
  } state_t;

  localparam int DATA_W_DEF = 8;
  localparam int ADDR_W_DEF = 4;
  localparam int N_RD_DEF   = 2;
  localparam int DR_IDX_DEF = 0;
  localparam int BYPASS_DEF = 1;

endpackage

// File: rtl/reg_file_scoreboard.sv
// Pending-load scoreboard: one bit per register, set on load issue,
// cleared on writeback, flushed wholesale; N_RD combinational lookups.
// Ports: clk, rst_n, flush, set_en/set_addr, clr_en/clr_addr,
//        raddr (packed N_RD indices), busy (pending bit per port).
module reg_file_scoreboard #(
  parameter int ADDR_W = 4,
  parameter int N_RD   = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               flush,
  input  logic               set_en,
  input  logic [ADDR_W-1:0]  set_addr,
  input  logic               clr_en,
  input  logic [ADDR_W-1:0]  clr_addr,
  input  logic [N_RD*ADDR_W-1:0] raddr,
  output logic [N_RD-1:0]    busy
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [DEPTH-1:0] pending;

  // Set is applied after clear so a same-address collision ends set.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending <= '0;
    end else if (flush) begin
      pending <= '0;
    end else begin
      if (clr_en) pending[clr_addr] <= 1'b0;
      if (set_en) pending[set_addr] <= 1'b1;
    end
  end

  for (genvar k = 0; k < N_RD; k++) begin : g_look
    assign busy[k] = pending[raddr[k*ADDR_W +: ADDR_W]];
  end

endmodule

// File: rtl/reg_file_gen.sv
// Parametrised register file with N read ports, write bypass,
// indirect read via a designated register, pending scoreboard
// and a sequenced zero sweep after reset or on clr_req.
// Ports: clk, rst_n, clr_req, write_en/waddr/data_in, pend_set/pend_addr,
//        raddr/data_out/busy, dr_code, data_ind, ready, clr_done.
module reg_file_gen
  import reg_file_gen_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int N_RD   = N_RD_DEF,
  parameter int DR_IDX = DR_IDX_DEF,
  parameter int BYPASS = BYPASS_DEF
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   clr_req,
  input  logic                   write_en,
  input  logic [ADDR_W-1:0]      waddr,
  input  logic [DATA_W-1:0]      data_in,
  input  logic                   pend_set,
  input  logic [ADDR_W-1:0]      pend_addr,
  input  logic [N_RD*ADDR_W-1:0] raddr,
  output logic [N_RD*DATA_W-1:0] data_out,
  output logic [N_RD-1:0]        busy,
  output logic [ADDR_W-1:0]      dr_code,
  output logic [DATA_W-1:0]      data_ind,
  output logic                   ready,
  output logic                   clr_done
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [ADDR_W-1:0] DR_A = ADDR_W'(DR_IDX);

  state_t state, state_nx;
  logic [ADDR_W-1:0] clr_idx, clr_idx_nx;
  logic clr_done_q, clr_done_nx;

  logic [DATA_W-1:0] regs [DEPTH];

  logic run;
  logic wr_ok;

  assign run   = (state == RUN);
  // A write coinciding with clr_req is dropped.
  assign wr_ok = run & write_en & ~clr_req;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= CLEAR;
      clr_idx    <= '0;
      clr_done_q <= 1'b0;
    end else begin
      state      <= state_nx;
      clr_idx    <= clr_idx_nx;
      clr_done_q <= clr_done_nx;
    end
  end

  always_comb begin
    state_nx    = state;
    clr_idx_nx  = clr_idx;
    clr_done_nx = 1'b0;
    unique case (state)
      CLEAR: begin
        clr_idx_nx = clr_idx + 1'b1;
        if (clr_idx == '1) begin
          state_nx    = RUN;
          clr_done_nx = 1'b1;
        end
      end
      RUN: begin
        if (clr_req) begin
          state_nx   = CLEAR;
          clr_idx_nx = '0;
        end
      end
      default: state_nx = CLEAR;
    endcase
  end

  // Array has no reset; the sweep zeroes it so it can map to RAM.
  always_ff @(posedge clk) begin
    if (!run) begin
      regs[clr_idx] <= '0;
    end else if (wr_ok) begin
      regs[waddr] <= data_in;
    end
  end

  for (genvar k = 0; k < N_RD; k++) begin : g_rd
    logic [ADDR_W-1:0] ra;
    logic              fwd;
    logic [DATA_W-1:0] rd;
    assign ra  = raddr[k*ADDR_W +: ADDR_W];
    assign fwd = (BYPASS != 0) && wr_ok && (waddr == ra);
    assign rd  = fwd ? data_in : regs[ra];
    assign data_out[k*DATA_W +: DATA_W] = run ? rd : '0;
  end

  // Two-level bypass: the pointer itself may be forwarded, and the
  // operand it selects may be forwarded again.
  logic              fwd_dr;
  logic [ADDR_W-1:0] ptr;
  logic              fwd_ind;
  logic [DATA_W-1:0] ind;

  assign fwd_dr  = (BYPASS != 0) && wr_ok && (waddr == DR_A);
  assign ptr     = fwd_dr ? data_in[ADDR_W-1:0]
                          : regs[DR_A][ADDR_W-1:0];
  assign fwd_ind = (BYPASS != 0) && wr_ok && (waddr == ptr);
  assign ind     = fwd_ind ? data_in : regs[ptr];

  assign dr_code  = run ? ptr : '0;
  assign data_ind = run ? ind : '0;
  assign ready    = run;
  assign clr_done = clr_done_q;

  logic [N_RD-1:0] busy_raw;

  reg_file_scoreboard #(
    .ADDR_W (ADDR_W),
    .N_RD   (N_RD)
  ) u_sb (
    .clk      (clk),
    .rst_n    (rst_n),
    .flush    (run & clr_req),
    .set_en   (run & pend_set & ~clr_req),
    .set_addr (pend_addr),
    .clr_en   (wr_ok),
    .clr_addr (waddr),
    .raddr    (raddr),
    .busy     (busy_raw)
  );

  assign busy = run ? busy_raw : '0;

endmodule

// File: tb/tb_reg_file_gen.sv
// Self-checking bench for reg_file_gen (bypass and non-bypass builds).
// Expected values are queued as stimulus is driven and drained at negedge.
module tb_reg_file_gen;

  localparam int AW = 4;
  localparam int DW = 8;
  localparam int NR = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic clr_req = 1'b0;
  logic write_en = 1'b0;
  logic pend_set = 1'b0;
  logic [AW-1:0] waddr = '0;
  logic [AW-1:0] pend_addr = '0;
  logic [DW-1:0] data_in = '0;
  logic [NR*AW-1:0] raddr = '0;

  logic [NR*DW-1:0] a_do, b_do;
  logic [NR-1:0] a_busy, b_busy;
  logic [AW-1:0] a_dr, b_dr;
  logic [DW-1:0] a_ind, b_ind;
  logic a_rdy, b_rdy, a_cd, b_cd;

  always #5 clk = ~clk;

  reg_file_gen #(.BYPASS(1)) dut (
    .clk(clk), .rst_n(rst_n), .clr_req(clr_req),
    .write_en(write_en), .waddr(waddr), .data_in(data_in),
    .pend_set(pend_set), .pend_addr(pend_addr), .raddr(raddr),
    .data_out(a_do), .busy(a_busy), .dr_code(a_dr),
    .data_ind(a_ind), .ready(a_rdy), .clr_done(a_cd)
  );

  reg_file_gen #(.BYPASS(0)) dut_nb (
    .clk(clk), .rst_n(rst_n), .clr_req(clr_req),
    .write_en(write_en), .waddr(waddr), .data_in(data_in),
    .pend_set(pend_set), .pend_addr(pend_addr), .raddr(raddr),
    .data_out(b_do), .busy(b_busy), .dr_code(b_dr),
    .data_ind(b_ind), .ready(b_rdy), .clr_done(b_cd)
  );

  typedef struct {
    string       tag;
    int          sel;
    logic [31:0] val;
  } exp_t;

  exp_t q[$];
  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] probe(input int sel);
    case (sel)
      0: return 32'(a_do[DW-1:0]);
      1: return 32'(a_do[2*DW-1:DW]);
      2: return 32'(a_busy);
      3: return 32'(a_dr);
      4: return 32'(a_ind);
      5: return 32'(a_rdy);
      6: return 32'(a_cd);
      7: return 32'(b_do[DW-1:0]);
      8: return 32'(b_dr);
      9: return 32'(b_rdy);
      default: return 32'hDEAD;
    endcase
  endfunction

  task automatic expect_v(input string tag, input int sel,
                          input logic [31:0] v);
    exp_t e;
    e.tag = tag;
    e.sel = sel;
    e.val = v;
    q.push_back(e);
  endtask

  task automatic drain();
    exp_t e;
    while (q.size() > 0) begin
      e = q.pop_front();
      check(e.tag, probe(e.sel), e.val);
    end
  endtask

  task automatic cycle();
    @(negedge clk);
    drain();
    @(posedge clk);
    #1;
  endtask

  task automatic set_rd(input logic [AW-1:0] r0, input logic [AW-1:0] r1);
    raddr = {r1, r0};
  endtask

  task automatic wr(input logic [AW-1:0] a, input logic [DW-1:0] d);
    write_en = 1'b1;
    waddr = a;
    data_in = d;
  endtask

  // Counts ready-low negedges after a release; bounded.
  task automatic wait_ready(input string tag);
    int n;
    n = 0;
    @(negedge clk);
    while (!a_rdy && n < 64) begin
      n++;
      @(negedge clk);
    end
    check({tag, "_len"}, 32'(n), 32'd16);
    check({tag, "_done"}, 32'(a_cd), 32'd1);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #2;
    expect_v("rst_ready", 5, 0);
    expect_v("rst_do0", 0, 0);
    expect_v("rst_cd", 6, 0);
    drain();
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    for (int i = 0; i < 16; i++) begin
      expect_v("sweep_ready", 5, 0);
      expect_v("sweep_cd", 6, 0);
      cycle();
    end
    expect_v("run_ready", 5, 1);
    expect_v("run_cd", 6, 1);
    expect_v("nb_ready", 9, 1);
    cycle();
    expect_v("cd_pulse_end", 6, 0);
    cycle();

    for (int i = 0; i < 8; i++) begin
      set_rd(AW'(i), AW'(15 - i));
      expect_v("zero_rd0", 0, 0);
      expect_v("zero_rd1", 1, 0);
      expect_v("zero_busy", 2, 0);
      cycle();
    end

    set_rd(4'd3, 4'd0);
    wr(4'd3, 8'hA5);
    expect_v("byp_on", 0, 32'hA5);
    expect_v("byp_off", 7, 32'h00);
    cycle();
    write_en = 1'b0;
    expect_v("after_on", 0, 32'hA5);
    expect_v("after_off", 7, 32'hA5);
    cycle();

    wr(4'd0, 8'h07);
    cycle();
    wr(4'd7, 8'h3C);
    expect_v("ind_fwd_code", 3, 7);
    expect_v("ind_fwd_data", 4, 32'h3C);
    cycle();
    write_en = 1'b0;
    expect_v("ind_code", 3, 7);
    expect_v("ind_data", 4, 32'h3C);
    cycle();
    wr(4'd0, 8'h02);
    expect_v("ptr_fwd_code", 3, 2);
    expect_v("ptr_fwd_data", 4, 0);
    expect_v("ptr_nb_code", 8, 7);
    cycle();
    write_en = 1'b0;

    set_rd(4'd3, 4'd5);
    pend_set = 1'b1;
    pend_addr = 4'd5;
    expect_v("pend_same_cyc", 2, 0);
    cycle();
    pend_set = 1'b0;
    expect_v("pend_busy", 2, 32'b10);
    cycle();
    wr(4'd5, 8'h11);
    expect_v("wb_busy_hold", 2, 32'b10);
    expect_v("wb_data_fwd", 1, 32'h11);
    cycle();
    write_en = 1'b0;
    expect_v("wb_busy_clr", 2, 0);
    cycle();
    wr(4'd5, 8'h22);
    pend_set = 1'b1;
    pend_addr = 4'd5;
    cycle();
    write_en = 1'b0;
    pend_set = 1'b0;
    expect_v("set_wins", 2, 32'b10);
    cycle();

    set_rd(4'd9, 4'd5);
    clr_req = 1'b1;
    wr(4'd9, 8'hFF);
    expect_v("clr_req_ready", 5, 1);
    cycle();
    clr_req = 1'b0;
    write_en = 1'b0;
    for (int i = 0; i < 16; i++) begin
      expect_v("clr_ready", 5, 0);
      expect_v("clr_do1", 1, 0);
      expect_v("clr_ind", 4, 0);
      cycle();
    end
    expect_v("clr_back", 5, 1);
    expect_v("clr_cd", 6, 1);
    expect_v("r9_dropped", 0, 0);
    expect_v("r5_cleared", 1, 0);
    expect_v("pend_flushed", 2, 0);
    expect_v("dr_cleared", 3, 0);
    cycle();

    wr(4'd3, 8'h5A);
    cycle();
    write_en = 1'b0;
    set_rd(4'd3, 4'd3);
    expect_v("pre_rst_rd", 0, 32'h5A);
    cycle();
    rst_n = 1'b0;
    #2;
    expect_v("async_ready", 5, 0);
    expect_v("async_do0", 0, 0);
    drain();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    wait_ready("rst_run");

    clr_req = 1'b1;
    cycle();
    clr_req = 1'b0;
    repeat (6) cycle();
    rst_n = 1'b0;
    #2;
    expect_v("mid_ready", 5, 0);
    expect_v("mid_do0", 0, 0);
    expect_v("mid_dr", 3, 0);
    drain();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    wait_ready("mid_sweep");
    expect_v("mid_r3_zero", 0, 0);
    cycle();

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
